// File: rtl/serial_sub_16bits.sv
// Digit-serial subtractor: Diff = A - B - Bin, one DIGIT-bit digit per clock,
// least-significant digit first, with a registered borrow between digits.
// Results (Diff/Bout/Zero/Ovf) update only on completion and hold until the next one.
// WIDTH must be a multiple of DIGIT, and DIGIT must be at least 1.
`timescale 1ns/1ps
module serial_sub_16bits #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Ovf
);

    localparam int unsigned NSTEP = WIDTH / DIGIT;
    localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rres;
    logic             brw;

    logic [DIGIT:0]   dig_full;
    logic             dig_bout;
    logic             msb_bin;
    logic [WIDTH-1:0] res_next;
    logic             last;

    // One digit of subtraction plus the shifted-in result; the borrow into the
    // digit's top bit is recovered from the sum bit (d = a ^ b ^ borrow_in).
    always_comb begin
        dig_full = {1'b0, ra[DIGIT-1:0]} - {1'b0, rb[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};
        dig_bout = dig_full[DIGIT];
        msb_bin  = dig_full[DIGIT-1] ^ ra[DIGIT-1] ^ rb[DIGIT-1];
        res_next = rres >> DIGIT;
        res_next[WIDTH-1 -: DIGIT] = dig_full[DIGIT-1:0];
        last     = (cnt == CW'(NSTEP - 1));
    end

    // Control FSM and datapath registers; outputs registered, loaded on the last step.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            rres  <= '0;
            brw   <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            Zero  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        ra    <= A;
                        rb    <= B;
                        brw   <= Bin;
                        cnt   <= '0;
                        rres  <= '0;
                        state <= RUN;
                        Busy  <= 1'b1;
                    end
                end
                RUN: begin
                    rres <= res_next;
                    ra   <= ra >> DIGIT;
                    rb   <= rb >> DIGIT;
                    brw  <= dig_bout;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        Diff  <= res_next;
                        Bout  <= dig_bout;
                        Zero  <= (res_next == '0);
                        Ovf   <= msb_bin ^ dig_bout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_16bits.sv
// Self-checking bench for serial_sub_16bits: directed vectors, random operands,
// back-to-back issue, Start-while-busy and asynchronous reset mid-operation.
`timescale 1ns/1ps
module tb_serial_sub_16bits;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        Busy;
    logic        Done;
    logic [15:0] Diff;
    logic        Bout;
    logic        Zero;
    logic        Ovf;

    int checks = 0;
    int errors = 0;

    serial_sub_16bits #(.WIDTH(16), .DIGIT(4)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Busy  (Busy),
        .Done  (Done),
        .Diff  (Diff),
        .Bout  (Bout),
        .Zero  (Zero),
        .Ovf   (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output logic [15:0] d, output logic bo, output logic z,
                         output logic ov);
        int full;
        int sd;
        full = int'(a) - int'(b) - int'(bin);
        d    = 16'(full);
        bo   = (full < 0);
        z    = (d == 16'h0000);
        sd   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ov   = (sd > 32767) || (sd < -32768);
    endtask

    // Issue one operation, scramble inputs while busy, optionally poke Start mid-run.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input bit poke);
        logic [15:0] ed;
        logic        eb, ez, eo;
        int          cyc;
        int          busy_n;
        model(a, b, bin, ed, eb, ez, eo);
        @(negedge Clk);
        A = a; B = b; Bin = bin; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("busy_after_start", 32'(Busy), 32'd1);
        cyc = 0;
        busy_n = 0;
        while (!Done && cyc < 12) begin
            if (Busy) busy_n++;
            A = 16'($urandom);
            B = 16'($urandom);
            Bin = 1'($urandom);
            Start = poke && (cyc == 1);
            @(negedge Clk);
            cyc++;
        end
        Start = 1'b0;
        check("done_seen",   32'(Done), 32'd1);
        check("busy_cycles", 32'(busy_n), 32'd4);
        check("busy_at_done", 32'(Busy), 32'd0);
        check("diff", 32'(Diff), 32'(ed));
        check("bout", 32'(Bout), 32'(eb));
        check("zero", 32'(Zero), 32'(ez));
        check("ovf",  32'(Ovf),  32'(eo));
        @(negedge Clk);
        check("done_one_cycle", 32'(Done), 32'd0);
        check("busy_after_done", 32'(Busy), 32'd0);
        check("diff_hold", 32'(Diff), 32'(ed));
    endtask

    initial begin
        logic [15:0] ed;
        logic        eb, ez, eo;
        int          cyc;
        int          done_cnt;

        Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_flags", 32'({Bout, Zero, Ovf}), 32'd0);
        Rst_n = 1'b1;

        // Directed vectors
        run_op(16'hA51B, 16'h52BB, 1'b0, 1'b0);
        check("vec1_diff_const", 32'(Diff), 32'h5260);
        check("vec1_ovf_const",  32'(Ovf),  32'd1);
        run_op(16'h372D, 16'hF359, 1'b0, 1'b0);
        check("vec2_diff_const", 32'(Diff), 32'h43D4);
        check("vec2_bout_const", 32'(Bout), 32'd1);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        check("vec3_zero_const", 32'(Zero), 32'd1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        check("vec4_diff_const", 32'(Diff), 32'hFFFF);
        check("vec4_bout_const", 32'(Bout), 32'd1);

        // Back-to-back with Start held through the Done cycle
        @(negedge Clk);
        A = 16'h8000; B = 16'h0001; Bin = 1'b0; Start = 1'b1;
        @(negedge Clk);
        A = 16'h0000; B = 16'h0001;
        cyc = 0;
        while (!Done && cyc < 12) begin
            @(negedge Clk);
            cyc++;
        end
        check("b2b_done1", 32'(Done), 32'd1);
        check("b2b_diff1", 32'(Diff), 32'h7FFF);
        check("b2b_ovf1",  32'(Ovf),  32'd1);
        check("b2b_bout1", 32'(Bout), 32'd0);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
        end while (!Done && cyc < 12);
        model(16'h0000, 16'h0001, 1'b0, ed, eb, ez, eo);
        check("b2b_spacing", 32'(cyc), 32'd5);
        check("b2b_diff2", 32'(Diff), 32'(ed));
        check("b2b_bout2", 32'(Bout), 32'(eb));
        check("b2b_ovf2",  32'(Ovf),  32'(eo));

        // Start while busy must be ignored
        run_op(16'h1234, 16'h0F0F, 1'b1, 1'b1);
        done_cnt = 0;
        repeat (6) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        check("poke_no_extra_done", 32'(done_cnt), 32'd0);

        // Random operands against the model
        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        end

        // Leave a known nonzero result, then reset mid-operation
        run_op(16'h0005, 16'h0009, 1'b0, 1'b0);
        @(negedge Clk);
        A = 16'h4444; B = 16'h1111; Bin = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_done", 32'(Done), 32'd0);
        check("arst_diff", 32'(Diff), 32'd0);
        check("arst_bout", 32'(Bout), 32'd0);
        check("arst_zero", 32'(Zero), 32'd0);
        check("arst_ovf",  32'(Ovf),  32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        done_cnt = 0;
        repeat (8) begin
            @(negedge Clk);
            if (Done || Busy) done_cnt++;
        end
        check("arst_no_done", 32'(done_cnt), 32'd0);
        run_op(16'h4444, 16'h1111, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
